// File: rtl/bpm_pkg.sv
// Shared types and constants for the BPM divider scheduler.
package bpm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DIV   = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int DIV_W = 32;

  // Numerator of the BPM division: beats per minute = 60 * f_clk / interval.
  function automatic logic [DIV_W-1:0] bpm_num(input int unsigned clk_freq);
    return DIV_W'(60 * clk_freq);
  endfunction

endpackage

// File: rtl/bpm_serial_div.sv
// Restoring unsigned divider, one quotient bit per cycle, 32 iterations.
// The dividend is shifted out of the quotient register MSB-first while the
// quotient bits are shifted in behind it.
module bpm_serial_div
  import bpm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  logic [DIV_W-1:0] q;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] dvs;
  logic [5:0]       cnt;   // iterations remaining; zero when idle

  logic [DIV_W:0]   rem_shift;
  logic             ge;
  logic [DIV_W-1:0] rem_sub;

  // Trial subtraction for the current iteration.
  always_comb begin
    rem_shift = {rem, q[DIV_W-1]};
    ge        = (rem_shift >= {1'b0, dvs});
    // The partial remainder is always below the divisor, so the difference fits.
    rem_sub   = rem_shift[DIV_W-1:0] - dvs;
  end

  // Iteration register: load on start, then shift/subtract until cnt expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would chain rem into q within one edge.
      q   <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= 6'd32;
    end else if (cnt != 6'd0) begin
      rem <= ge ? rem_sub : rem_shift[DIV_W-1:0];
      q   <= {q[DIV_W-2:0], ge};
      cnt <= cnt - 6'd1;
    end
  end

  // High during the cycle whose closing edge performs the 32nd iteration.
  assign done     = (cnt == 6'd1);
  assign quotient = q;

endmodule

// File: rtl/bpm_div_sched.sv
// Round-robin scheduler sharing one serial divider among NCH heart-rate
// channels. Each accepted R-R interval is converted to BPM and written to
// that channel's result register with a one-cycle valid pulse.
module bpm_div_sched
  import bpm_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 200,
  parameter int          NCH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_valid,
  output logic [NCH-1:0]       req_ready,
  input  logic [DIV_W*NCH-1:0] rr_cycles,
  output logic [DIV_W*NCH-1:0] bpm_out,
  output logic [NCH-1:0]       bpm_valid,
  output logic [NCH-1:0]       err_zero,
  output logic                 busy
);

  localparam logic [DIV_W-1:0] NUM = bpm_num(CLK_FREQ);
  localparam int               IW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           state, state_n;
  logic [NCH-1:0]   pending;
  logic [DIV_W-1:0] hold [NCH];
  logic [IW-1:0]    grant;
  logic [IW-1:0]    last_grant;
  logic             zero_flag;
  logic             settle;      // one idle cycle after each WRITE

  logic [IW-1:0]    arb_idx;
  logic             arb_found;
  logic [DIV_W-1:0] hold_g;
  logic             div_start;
  logic [DIV_W-1:0] quotient;
  logic             div_done;

  assign hold_g    = hold[grant];
  assign req_ready = ~pending;
  assign busy      = (state != IDLE);

  // Round-robin search: first pending channel at or after last_grant+1, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    arb_idx   = last_grant;
    arb_found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      if (!arb_found && pending[(int'(last_grant) + k) % NCH]) begin
        arb_found = 1'b1;
        arb_idx   = IW'((int'(last_grant) + k) % NCH);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next state and divider start strobe.
  always_comb begin
    state_n   = state;
    div_start = 1'b0;
    case (state)
      // The settle cycle lets a channel re-accepted on the edge after WRITE
      // take part in the next arbitration round.
      IDLE:    if (arb_found && !settle) state_n = LOAD;
      LOAD: begin
        if (hold_g == '0) begin
          state_n = WRITE;
        end else begin
          state_n   = DIV;
          div_start = 1'b1;
        end
      end
      DIV:     if (div_done) state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control registers: grant, round-robin pointer, zero flag, settle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= IW'(NCH - 1);
      zero_flag  <= 1'b0;
      settle     <= 1'b0;
    end else begin
      settle <= (state == WRITE);
      if (state == IDLE && state_n == LOAD) grant <= arb_idx;
      if (state == LOAD) zero_flag <= (hold_g == '0);
      if (state == WRITE) last_grant <= grant;
    end
  end

  // Per-channel request capture; the served channel is released at WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      // NOTE: hold is a small register array, not RAM, and reset clears it so
      // no stale interval survives reset; RAM-style storage would not be reset.
      for (int i = 0; i < NCH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (req_valid[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          hold[i]    <= rr_cycles[DIV_W*i +: DIV_W];
        end
      end
      if (state == WRITE) pending[grant] <= 1'b0;
    end
  end

  // Result registers and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bpm_out   <= '0;
      bpm_valid <= '0;
      err_zero  <= '0;
    end else begin
      bpm_valid <= '0;
      err_zero  <= '0;
      if (state == WRITE) begin
        if (zero_flag) begin
          err_zero[grant] <= 1'b1;
        end else begin
          bpm_out[DIV_W*int'(grant) +: DIV_W] <= quotient;
          bpm_valid[grant]                    <= 1'b1;
        end
      end
    end
  end

  bpm_serial_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (NUM),
    .divisor  (hold_g),
    .quotient (quotient),
    .done     (div_done)
  );

endmodule

// File: tb/tb_bpm_div_sched.sv
// Self-checking bench for bpm_div_sched: directed latency/ordering scenarios
// plus a randomized run checked against a per-channel result queue model.
module tb_bpm_div_sched;

  localparam int unsigned CLK_FREQ = 200;
  localparam int          NCH      = 4;
  localparam logic [31:0] NUM      = 32'(60 * CLK_FREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      req_valid;
  logic [NCH-1:0]      req_ready;
  logic [32*NCH-1:0]   rr_cycles;
  logic [32*NCH-1:0]   bpm_out;
  logic [NCH-1:0]      bpm_valid;
  logic [NCH-1:0]      err_zero;
  logic                busy;

  int n_vec = 0;
  int n_bad = 0;

  bpm_div_sched #(.CLK_FREQ(CLK_FREQ), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rr_cycles (rr_cycles),
    .bpm_out   (bpm_out),
    .bpm_valid (bpm_valid),
    .err_zero  (err_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rr_cycles = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One-cycle request; the accept edge is the edge consumed here.
  task automatic send(input int ch, input logic [31:0] rr);
    req_valid[ch]          = 1'b1;
    rr_cycles[32*ch +: 32] = rr;
    tick();
    req_valid[ch]          = 1'b0;
    rr_cycles[32*ch +: 32] = $urandom;  // latched copy must be used
  endtask

  // Single request with the 35-cycle latency and busy profile checked.
  task automatic run_one(input int ch, input logic [31:0] rr, input logic [31:0] exp_bpm);
    logic [NCH-1:0] want;
    want     = '0;
    want[ch] = 1'b1;
    send(ch, rr);
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k < 35) begin
        n_vec++;
        if (bpm_valid !== '0 || err_zero !== '0 || busy !== 1'b1 || req_ready[ch] !== 1'b0) begin
          n_bad++;
          $display("FAIL run_one ch%0d k=%0d: valid=%b err=%b busy=%b ready=%b, want 0 0 1 0",
                   ch, k, bpm_valid, err_zero, busy, req_ready[ch]);
        end
      end else begin
        n_vec++;
        if (bpm_valid !== want || err_zero !== '0) begin
          n_bad++;
          $display("FAIL run_one_pulse ch%0d: valid=%b err=%b, want valid=%b err=0",
                   ch, bpm_valid, err_zero, want);
        end
        n_vec++;
        if (bpm_out[32*ch +: 32] !== exp_bpm) begin
          n_bad++;
          $display("FAIL run_one_value ch%0d rr=%0d: got %0d, want %0d",
                   ch, rr, bpm_out[32*ch +: 32], exp_bpm);
        end
      end
    end
    tick();
    n_vec++;
    if (bpm_valid !== '0 || busy !== 1'b0 || req_ready !== '1) begin
      n_bad++;
      $display("FAIL run_one_after ch%0d: valid=%b busy=%b ready=%b, want 0 0 1111",
               ch, bpm_valid, busy, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++;
    if (req_ready !== '1 || bpm_out !== '0 || bpm_valid !== '0 || err_zero !== '0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: ready=%b out=%h valid=%b err=%b busy=%b, want 1111 0 0 0 0",
               req_ready, bpm_out, bpm_valid, err_zero, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    run_one(0, 32'd100, 32'd120);
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_v [4];
    int got_ch [4];
    int got_k  [4];
    logic [31:0] got_v [4];
    int n;
    exp_v = '{32'd120, 32'd60, 32'd1, 32'd12000};
    n = 0;
    do_reset();
    req_valid = '1;
    rr_cycles = {32'd1, 32'd12000, 32'd200, 32'd100};
    tick();
    req_valid = '0;
    rr_cycles = '0;
    for (int k = 1; k <= 160; k++) begin
      tick();
      if (bpm_valid !== '0) begin
        n_vec++;
        if (!$onehot(bpm_valid) || err_zero !== '0) begin
          n_bad++;
          $display("FAIL simul_onehot k=%0d: valid=%b err=%b, want one valid bit", k, bpm_valid, err_zero);
        end
        if (n < 4) begin
          for (int c = 0; c < NCH; c++) if (bpm_valid[c]) got_ch[n] = c;
          got_k[n] = k;
          got_v[n] = bpm_out[32*got_ch[n] +: 32];
        end
        n++;
      end
    end
    n_vec++;
    if (n != 4) begin
      n_bad++;
      $display("FAIL simul_count: got %0d pulses, want 4", n);
    end
    for (int j = 0; j < 4 && j < n; j++) begin
      n_vec++;
      if (got_ch[j] != j || got_k[j] != 35 + 36*j || got_v[j] !== exp_v[j]) begin
        n_bad++;
        $display("FAIL simul_result%0d: ch=%0d cyc=%0d val=%0d, want ch=%0d cyc=%0d val=%0d",
                 j, got_ch[j], got_k[j], got_v[j], j, 35 + 36*j, exp_v[j]);
      end
    end
  endtask

  task automatic test_zero();
    do_reset();
    run_one(2, 32'd100, 32'd120);
    send(2, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++;
      if (k == 3) begin
        if (err_zero !== 4'b0100 || bpm_valid !== '0 || req_ready[2] !== 1'b1) begin
          n_bad++;
          $display("FAIL zero_pulse: err=%b valid=%b ready2=%b, want 0100 0000 1",
                   err_zero, bpm_valid, req_ready[2]);
        end
      end else if (err_zero !== '0 || bpm_valid !== '0) begin
        n_bad++;
        $display("FAIL zero_quiet k=%0d: err=%b valid=%b, want 0 0", k, err_zero, bpm_valid);
      end
    end
    n_vec++;
    if (bpm_out[64 +: 32] !== 32'd120) begin
      n_bad++;
      $display("FAIL zero_retain: got %0d, want 120", bpm_out[64 +: 32]);
    end
  endtask

  task automatic test_fairness();
    int seq_ch [6];
    int seq_k  [6];
    logic [31:0] seq_v [6];
    int n;
    n = 0;
    do_reset();
    req_valid[0] = 1'b1; rr_cycles[0  +: 32] = 32'd100;
    req_valid[3] = 1'b1; rr_cycles[96 +: 32] = 32'd200;
    tick();
    req_valid = '0;
    for (int k = 1; k <= 300 && n < 6; k++) begin
      tick();
      req_valid = '0;
      if (bpm_valid !== '0) begin
        for (int c = 0; c < NCH; c++) begin
          if (bpm_valid[c]) begin
            seq_ch[n] = c;
            seq_k[n]  = k;
            seq_v[n]  = bpm_out[32*c +: 32];
          end
        end
        n++;
        // Re-request immediately so the served channel competes again.
        if (bpm_valid[0]) begin req_valid[0] = 1'b1; rr_cycles[0  +: 32] = 32'd100; end
        if (bpm_valid[3]) begin req_valid[3] = 1'b1; rr_cycles[96 +: 32] = 32'd200; end
      end
    end
    req_valid = '0;
    n_vec++;
    if (n != 6) begin
      n_bad++;
      $display("FAIL fair_count: got %0d pulses, want 6", n);
    end
    for (int j = 0; j < 6 && j < n; j++) begin
      n_vec++;
      if (seq_ch[j] != ((j % 2 == 0) ? 0 : 3) || seq_k[j] != 35 + 36*j ||
          seq_v[j] !== ((j % 2 == 0) ? 32'd120 : 32'd60)) begin
        n_bad++;
        $display("FAIL fair_grant%0d: ch=%0d cyc=%0d val=%0d, want ch=%0d cyc=%0d",
                 j, seq_ch[j], seq_k[j], seq_v[j], (j % 2 == 0) ? 0 : 3, 35 + 36*j);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    run_one(1, 32'd100, 32'd120);
    run_one(1, 32'd12001, 32'd0);
    run_one(2, 32'd6000, 32'd2);
    run_one(2, 32'hFFFF_FFFF, 32'd0);
    run_one(3, 32'd12000, 32'd1);
  endtask

  task automatic test_reset_mid_div();
    logic seen;
    seen = 1'b0;
    do_reset();
    run_one(0, 32'd100, 32'd120);
    send(1, 32'd5000);
    repeat (12) tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL middiv_busy: got %b, want 1", busy);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== '1 || bpm_out !== '0 || bpm_valid !== '0 || err_zero !== '0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL middiv_reset: ready=%b out=%h valid=%b err=%b busy=%b, want 1111 0 0 0 0",
               req_ready, bpm_out, bpm_valid, err_zero, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bpm_valid !== '0 || err_zero !== '0 || busy !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_bad++;
      $display("FAIL middiv_ghost: activity after reset, want none");
    end
    run_one(1, 32'd400, 32'd30);
  endtask

  // Randomized traffic; expected results are queued per channel at request time.
  task automatic test_random();
    logic [32:0] exp_q [NCH][$];
    logic [31:0] shadow [NCH];
    logic [31:0] rr;
    logic [32:0] e;
    logic        done;
    logic        empty;
    done = 1'b0;
    do_reset();
    for (int c = 0; c < NCH; c++) shadow[c] = '0;
    for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
      req_valid = '0;
      if (cyc < 1500) begin
        for (int c = 0; c < NCH; c++) begin
          if (req_ready[c] && $urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 6))
              0:       rr = 32'd0;
              1:       rr = 32'd1;
              2:       rr = 32'd12000;
              3:       rr = 32'd12001;
              4:       rr = 32'hFFFF_FFFF;
              5:       rr = 32'($urandom_range(1, 400));
              default: rr = $urandom;
            endcase
            req_valid[c]          = 1'b1;
            rr_cycles[32*c +: 32] = rr;
            exp_q[c].push_back((rr == 0) ? {1'b1, 32'd0} : {1'b0, NUM / rr});
          end
        end
      end
      tick();
      n_vec++;
      if (!$onehot0(bpm_valid | err_zero) || (bpm_valid & err_zero) !== '0) begin
        n_bad++;
        $display("FAIL rand_exclusive cyc=%0d: valid=%b err=%b, want at most one pulse", cyc, bpm_valid, err_zero);
      end
      for (int c = 0; c < NCH; c++) begin
        if (bpm_valid[c] || err_zero[c]) begin
          n_vec++;
          if (exp_q[c].size() == 0) begin
            n_bad++;
            $display("FAIL rand_unexpected ch%0d cyc=%0d: valid=%b err=%b, want no pulse",
                     c, cyc, bpm_valid[c], err_zero[c]);
          end else begin
            e = exp_q[c].pop_front();
            if (e[32]) begin
              if (err_zero[c] !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_zero ch%0d cyc=%0d: valid=%b err=%b, want err",
                         c, cyc, bpm_valid[c], err_zero[c]);
              end
            end else begin
              shadow[c] = e[31:0];
              if (bpm_valid[c] !== 1'b1 || bpm_out[32*c +: 32] !== e[31:0]) begin
                n_bad++;
                $display("FAIL rand_value ch%0d cyc=%0d: valid=%b out=%0d, want valid=1 out=%0d",
                         c, cyc, bpm_valid[c], bpm_out[32*c +: 32], e[31:0]);
              end
            end
          end
        end
        n_vec++;
        if (bpm_out[32*c +: 32] !== shadow[c]) begin
          n_bad++;
          $display("FAIL rand_hold ch%0d cyc=%0d: out=%0d, want %0d", c, cyc, bpm_out[32*c +: 32], shadow[c]);
        end
      end
      empty = 1'b1;
      for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) empty = 1'b0;
      if (cyc >= 1500 && empty && req_ready === '1) done = 1'b1;
    end
    req_valid = '0;
    n_vec++;
    if (!done) begin
      n_bad++;
      $display("FAIL rand_drain: outstanding requests after cycle budget, want none");
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rr_cycles = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_zero();
    test_fairness();
    test_overflow();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bpm_div_sched.md
# bpm_div_sched

Shared-divider scheduler for multi-channel heart-rate estimation. Each of NCH sensor channels delivers an R-R interval in clock cycles; the block arbitrates them round-robin onto one iterative 32-bit divider that computes BPM = (60·CLK_FREQ) / rr_cycles. Results go to per-channel output registers. It sits between the per-channel R-R interval counters and the display/report logic, replacing one combinational divider per channel.

## Interface
Parameters:
- CLK_FREQ, 200, clock frequency in Hz; 60·CLK_FREQ must fit in 32 bits
- NCH, 4, number of requesting channels (2..8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NCH  per-channel request strobe
- req_ready  out  NCH  per-channel accept; high when the channel has no pending request
- rr_cycles  in  32·NCH  flattened R-R intervals; channel i is bits [32i+31:32i]
- bpm_out  out  32·NCH  flattened per-channel BPM result registers
- bpm_valid  out  NCH  one-cycle pulse when bpm_out[i] updates
- err_zero  out  NCH  one-cycle pulse when channel i requested with rr_cycles = 0
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Accept: on a clock edge with req_valid[i] & req_ready[i], latch rr_cycles[i] into hold[i] and set pending[i]. req_ready[i] = ~pending[i]. Input may change after acceptance.
- Arbiter: in IDLE, grant the first pending channel, searching upward (with wrap) from last_grant+1. last_grant resets to NCH-1, so channel 0 has first priority after reset.
- FSM states: IDLE, LOAD, DIV, WRITE.
  - IDLE → LOAD when any pending; register grant index.
  - LOAD: if hold[g] = 0 → WRITE with zero flag; else start divider with dividend 60·CLK_FREQ and divisor hold[g] → DIV.
  - DIV: wait for divider done → WRITE.
  - WRITE: if zero flag, pulse err_zero[g] and leave bpm_out[g] unchanged; else load bpm_out[g] with the quotient and pulse bpm_valid[g]. Clear pending[g], update last_grant = g → IDLE.
- Divider: restoring, unsigned, one quotient bit per cycle, exactly 32 iterations. The quotient is truncated and the remainder discarded. A divisor larger than the dividend yields 0.
- A new request on a channel not being served is accepted at any time, including during DIV.
- The served channel stays not-ready until its WRITE edge. It may be re-accepted on the edge after WRITE.
- Reset (at any time, including mid-DIV): FSM to IDLE; pending, hold, bpm_out, bpm_valid, err_zero, and the divider cleared. No result is produced for interrupted requests.

## Timing
- Reset values: req_ready all 1, bpm_out all 0, bpm_valid 0, err_zero 0, busy 0.
- Normal latency: request accepted at edge E → bpm_valid high in the cycle after edge E+35:
  - E+1 enter LOAD
  - E+2 enter DIV
  - E+3..E+34 perform the 32 iterations; WRITE entered at E+34
  - E+35 results registered
- Zero-divisor latency: err_zero high after edge E+3.
- Back-to-back pending requests: consecutive result pulses are spaced 36 cycles apart (WRITE → IDLE → LOAD).
- bpm_valid and err_zero are registered, never both high for the same channel, and at most one channel pulses per cycle.

## Structure
- Shared package bpm_pkg:
  - state enum {IDLE, LOAD, DIV, WRITE}
  - DIV_W = 32
  - constant function bpm_num(CLK_FREQ) = 60·CLK_FREQ
- Sub-module bpm_serial_div:
  - Ports: clk, rst, start, dividend[31:0], divisor[31:0], quotient[31:0], done.
  - Owns the 6-bit iteration counter.
  - done pulses on the 32nd iteration edge; quotient is stable until the next start.
- The top level holds the FSM, the round-robin arbiter, and the per-channel hold, pending, and output registers.

## Test plan
- Single request: CLK_FREQ=200, channel 0 rr=100 → bpm_out[0]=120, with bpm_valid[0] pulsing after edge E+35; busy high from E+1 through E+35.
- Simultaneous requests: all four channels request on the same edge with rr = 100, 200, 12000, 1 → results 120, 60, 1, 12000, in channel order 0,1,2,3, spaced 36 cycles apart.
- Zero divisor: channel 2 rr=0 → err_zero[2] pulses after E+3; bpm_out[2] retains its previous value (120 from a prior request); req_ready[2] returns high.
- Fairness: channel 0 re-requests immediately after each result while channel 3 is pending → grants alternate 0,3,0,3; channel 3 is never starved.
- Overflow to zero: rr=12001 → bpm 0. Maximum rr=32'hFFFFFFFF → bpm 0 with the normal 35-cycle latency.
- Reset mid-DIV: assert rst 10 cycles into DIV on channel 1 → all outputs return to reset values immediately. After release, a fresh channel 1 request with rr=400 → bpm 30.
